// File: rtl/sram_responder.sv
// Device-side model of the external SRAM bus: array, pipelined reads, writes, standby/wake FSM.
// Optional access counters are built only when SRAM_RESPONDER_STATS_EN is defined.
module sram_responder #(
    parameter int RAM_WIDTH    = 8,
    parameter int RAM_DEPTH    = 16,
    parameter int READ_LATENCY = 1,
    parameter int WAKE_CYCLES  = 2,
    parameter int STATS_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RAM_DEPTH-1:0]   ram_address,
    inout  wire  [RAM_WIDTH-1:0]   ram_data,
    input  logic                   ram_cs,
    input  logic                   ram_we,
    output logic                   standby,
    output logic                   active,
    output logic                   contention,
    output logic [STATS_WIDTH-1:0] read_count,
    output logic [STATS_WIDTH-1:0] write_count
);

    localparam int MEM_WORDS = 1 << RAM_DEPTH;
    localparam logic [3:0] WAKE_LOAD = (WAKE_CYCLES == 0) ? 4'd0 : 4'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STANDBY,
        ST_WAKE,
        ST_ACTIVE
    } state_e;

    state_e state_q, state_d;
    logic [3:0] wake_cnt_q, wake_cnt_d;

    logic [RAM_WIDTH-1:0]    mem [MEM_WORDS];
    logic [RAM_WIDTH-1:0]    data_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] valid_q, valid_d;
    logic                    contention_q, contention_d;

    logic serve;
    logic rd_en;
    logic wr_en;
    logic head_valid;

    // With no wake delay, the access that leaves STANDBY is serviced in the same cycle.
    assign serve = !reset && !ram_cs &&
                   ((state_q == ST_ACTIVE) || ((state_q == ST_STANDBY) && (WAKE_CYCLES == 0)));
    assign rd_en = serve && ram_we;
    assign wr_en = serve && !ram_we;

    assign head_valid = valid_q[READ_LATENCY-1];

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_STANDBY: begin
                if (!ram_cs) begin
                    if (WAKE_CYCLES == 0) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d    = ST_WAKE;
                        wake_cnt_d = WAKE_LOAD;
                    end
                end
            end
            ST_WAKE: begin
                if (ram_cs) begin
                    state_d = ST_STANDBY;
                end else if (wake_cnt_q == 4'd0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    wake_cnt_d = wake_cnt_q - 4'd1;
                end
            end
            ST_ACTIVE: begin
                if (ram_cs) begin
                    state_d = ST_STANDBY;
                end
            end
            default: begin
                state_d = ST_STANDBY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_STANDBY;
            wake_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    // Pipeline valids shift every cycle regardless of state so issued beats always drain.
    always_comb begin
        valid_d    = valid_q << 1;
        valid_d[0] = rd_en;
        contention_d = contention_q || (head_valid && !ram_we);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= '0;
            contention_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            contention_q <= contention_d;
        end
    end

    // Array and data stages carry no reset so the array maps onto block RAM with a registered read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ram_address] <= ram_data;
        end
        if (rd_en) begin
            data_q[0] <= mem[ram_address];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign ram_data = (head_valid && ram_we) ? data_q[READ_LATENCY-1] : {RAM_WIDTH{1'bz}};

    assign standby    = (state_q == ST_STANDBY);
    assign active     = (state_q == ST_ACTIVE);
    assign contention = contention_q;

`ifdef SRAM_RESPONDER_STATS_EN
    logic [STATS_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [STATS_WIDTH-1:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_en && (rd_cnt_q != '1)) begin
            rd_cnt_d = rd_cnt_q + STATS_WIDTH'(1);
        end
        if (wr_en && (wr_cnt_q != '1)) begin
            wr_cnt_d = wr_cnt_q + STATS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;
`else
    assign read_count  = '0;
    assign write_count = '0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: two instances (read latency 1 and 2) share one controller stimulus.
// Read beats are scoreboarded by due cycle; every other undriven bus cycle must float high.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_cs;
    logic        ram_we;
    logic [15:0] ram_address;
    logic        tb_oe;
    logic [7:0]  tb_wdata;
    logic        mon_en;

    wire  [7:0]  bus1;
    wire  [7:0]  bus2;

    logic        sb1, act1, con1;
    logic        sb2, act2, con2;
    logic [15:0] rc1, wc1, rc2, wc2;

    always #5 clk = ~clk;

    assign bus1 = tb_oe ? tb_wdata : 8'bz;
    assign bus2 = tb_oe ? tb_wdata : 8'bz;
    pullup (bus1);
    pullup (bus2);

    sram_responder #(
        .RAM_WIDTH(8), .RAM_DEPTH(16), .READ_LATENCY(1), .WAKE_CYCLES(2), .STATS_WIDTH(16)
    ) u_l1 (
        .clk(clk), .reset(reset), .ram_address(ram_address), .ram_data(bus1),
        .ram_cs(ram_cs), .ram_we(ram_we), .standby(sb1), .active(act1),
        .contention(con1), .read_count(rc1), .write_count(wc1)
    );

    sram_responder #(
        .RAM_WIDTH(8), .RAM_DEPTH(16), .READ_LATENCY(2), .WAKE_CYCLES(2), .STATS_WIDTH(16)
    ) u_l2 (
        .clk(clk), .reset(reset), .ram_address(ram_address), .ram_data(bus2),
        .ram_cs(ram_cs), .ram_we(ram_we), .standby(sb2), .active(act2),
        .contention(con2), .read_count(rc2), .write_count(wc2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] data;
    } beat_t;

    beat_t q1[$];
    beat_t q2[$];

    typedef struct {
        logic        cs;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
        bit          rd;
        bit          sb;
        bit          act;
        bit          con;
    } vec_t;

    vec_t tbl[23];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h cycle=%0d", name, got, exp, cyc);
        end
    endtask

    // One bus cycle; p1/p2 schedule the expected beat for each latency.
    task automatic step(input logic cs, input logic we, input logic [15:0] a,
                        input logic [7:0] d, input bit p1, input bit p2);
        beat_t b;
        ram_cs      = cs;
        ram_we      = we;
        ram_address = a;
        tb_wdata    = d;
        tb_oe       = !we;
        b.data      = d;
        if (p1) begin
            b.due = cyc + 1;
            q1.push_back(b);
        end
        if (p2) begin
            b.due = cyc + 2;
            q2.push_back(b);
        end
        @(posedge clk);
        #1;
        $display("cyc %0d cs=%0b we=%0b addr=0x%04h data=0x%02h sb=%0b/%0b act=%0b/%0b con=%0b/%0b",
                 cyc, cs, we, a, d, sb1, sb2, act1, act2, con1, con2);
    endtask

    task automatic chk_state(input string tag, input bit sb, input bit act, input bit con);
        chk({tag, "_standby_l1"}, 32'(sb1), 32'(sb));
        chk({tag, "_active_l1"}, 32'(act1), 32'(act));
        chk({tag, "_contention_l1"}, 32'(con1), 32'(con));
        chk({tag, "_standby_l2"}, 32'(sb2), 32'(sb));
        chk({tag, "_active_l2"}, 32'(act2), 32'(act));
        chk({tag, "_contention_l2"}, 32'(con2), 32'(con));
    endtask

    task automatic wake_up();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (mon_en) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
                b = q1.pop_front();
                chk("read_beat_l1", 32'(bus1), 32'(b.data));
            end else if (!tb_oe) begin
                chk("bus_hiz_l1", 32'(bus1), 32'hFF);
            end
            if (q2.size() > 0 && q2[0].due == cyc) begin
                b = q2.pop_front();
                chk("read_beat_l2", 32'(bus2), 32'(b.data));
            end else if (!tb_oe) begin
                chk("bus_hiz_l2", 32'(bus2), 32'hFF);
            end
        end
    end

    initial begin
        logic [15:0] exp_rc;
        logic [15:0] exp_wc;

        //          cs    we    addr      data   rd sb act con
        tbl = '{
            '{1'b0, 1'b1, 16'h0000, 8'h00, 0, 0, 0, 0},
            '{1'b0, 1'b1, 16'h0000, 8'h00, 0, 0, 0, 0},
            '{1'b0, 1'b1, 16'h0000, 8'h00, 0, 0, 1, 0},
            '{1'b0, 1'b0, 16'h0005, 8'h5A, 0, 0, 1, 0},
            '{1'b0, 1'b0, 16'h0003, 8'hA5, 0, 0, 1, 0},
            '{1'b0, 1'b0, 16'h0010, 8'h11, 0, 0, 1, 0},
            '{1'b0, 1'b0, 16'h0011, 8'h22, 0, 0, 1, 0},
            '{1'b0, 1'b0, 16'h0012, 8'h33, 0, 0, 1, 0},
            '{1'b0, 1'b1, 16'h0003, 8'hA5, 1, 0, 1, 0},
            '{1'b0, 1'b1, 16'h0010, 8'h11, 1, 0, 1, 0},
            '{1'b0, 1'b1, 16'h0011, 8'h22, 1, 0, 1, 0},
            '{1'b0, 1'b1, 16'h0012, 8'h33, 1, 0, 1, 0},
            '{1'b1, 1'b1, 16'h0000, 8'h00, 0, 1, 0, 0},
            '{1'b1, 1'b1, 16'h0000, 8'h00, 0, 1, 0, 0},
            '{1'b0, 1'b0, 16'h0005, 8'h77, 0, 0, 0, 0},
            '{1'b0, 1'b0, 16'h0005, 8'h77, 0, 0, 0, 0},
            '{1'b0, 1'b0, 16'h0005, 8'h77, 0, 0, 1, 0},
            '{1'b0, 1'b0, 16'h0020, 8'h3C, 0, 0, 1, 0},
            '{1'b0, 1'b1, 16'h0020, 8'h3C, 1, 0, 1, 0},
            '{1'b0, 1'b1, 16'h0005, 8'h5A, 1, 0, 1, 0},
            '{1'b0, 1'b1, 16'h0010, 8'h11, 1, 0, 1, 0},
            '{1'b1, 1'b1, 16'h0000, 8'h00, 0, 1, 0, 0},
            '{1'b1, 1'b1, 16'h0000, 8'h00, 0, 1, 0, 0}
        };

        mon_en      = 1'b0;
        reset       = 1'b1;
        ram_cs      = 1'b1;
        ram_we      = 1'b1;
        ram_address = 16'h0000;
        tb_oe       = 1'b0;
        tb_wdata    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        chk_state("reset", 1'b1, 1'b0, 1'b0);
        chk("reset_read_count_l1", 32'(rc1), 32'h0);
        chk("reset_write_count_l1", 32'(wc1), 32'h0);

        for (int i = 0; i < $size(tbl); i++) begin
            step(tbl[i].cs, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].rd, tbl[i].rd);
            chk_state($sformatf("vec%0d", i), tbl[i].sb, tbl[i].act, tbl[i].con);
        end

        // Turnaround violation: the discarded read beat must flag, and the write must still land.
        wake_up();
        step(1'b0, 1'b1, 16'h0010, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0010, 8'h44, 1'b0, 1'b0);
        chk("turn1_contention_l1", 32'(con1), 32'h1);
        chk("turn1_contention_l2", 32'(con2), 32'h0);
        step(1'b0, 1'b0, 16'h0010, 8'h44, 1'b0, 1'b0);
        chk("turn2_contention_l1", 32'(con1), 32'h1);
        chk("turn2_contention_l2", 32'(con2), 32'h1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h0010, 8'h44, 1'b1, 1'b1);
        step(1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
        chk_state("sticky", 1'b1, 1'b0, 1'b1);

        // Reset one cycle after a read: latency-1 beat already out, latency-2 beat flushed.
        wake_up();
        step(1'b0, 1'b1, 16'h0012, 8'h33, 1'b1, 1'b0);
        reset = 1'b1;
        step(1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        chk_state("midreset", 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);

        // Counter sequence: 3 writes then 5 reads from a fresh reset.
        reset = 1'b1;
        step(1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        wake_up();
        step(1'b0, 1'b0, 16'h0030, 8'h01, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0031, 8'h02, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0032, 8'h03, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0030, 8'h01, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h0031, 8'h02, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h0032, 8'h03, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h0030, 8'h01, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h0031, 8'h02, 1'b1, 1'b1);
        step(1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
`ifdef SRAM_RESPONDER_STATS_EN
        exp_rc = 16'd5;
        exp_wc = 16'd3;
`else
        exp_rc = 16'd0;
        exp_wc = 16'd0;
`endif
        chk("read_count_l1", 32'(rc1), 32'(exp_rc));
        chk("write_count_l1", 32'(wc1), 32'(exp_wc));
        chk("read_count_l2", 32'(rc2), 32'(exp_rc));
        chk("write_count_l2", 32'(wc2), 32'(exp_wc));

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
        chk("pending_beats_l1", 32'(q1.size()), 32'h0);
        chk("pending_beats_l2", 32'(q2.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable responder for the external asynchronous-style SRAM bus driven by the memory controller. It is the device end of `ram_address`/`ram_data`/`ram_cs`/`ram_we`. It models the SRAM array, registered read latency, write commit, a standby/wake-up power state machine and bus-turnaround checking. It sits in simulation benches and FPGA builds in place of the physical SRAM, so the controller runs unchanged against it.

## Interface
- `RAM_WIDTH`, 8: data word width in bits.
- `RAM_DEPTH`, 16: address width in bits; array holds 2**RAM_DEPTH words.
- `READ_LATENCY`, 1: cycles from address sample to data driven; legal range 1..4.
- `WAKE_CYCLES`, 2: cycles spent in WAKE after chip select asserts from standby; legal range 0..15.
- `STATS_WIDTH`, 16: width of access counters (only used with stats enabled).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ram_address`  in  RAM_DEPTH  word address from controller.
- `ram_data`  inout  RAM_WIDTH  bidirectional data; the block drives it only during a valid read beat, otherwise high-Z.
- `ram_cs`  in  1  chip select, active-low (1 = deselected).
- `ram_we`  in  1  write enable, active-low (1 = read).
- `standby`  out  1  high while in STANDBY.
- `active`  out  1  high while in ACTIVE.
- `contention`  out  1  sticky; set when the controller drives a write while a read beat is due.
- `read_count`  out  STATS_WIDTH  accepted reads (stats build only).
- `write_count`  out  STATS_WIDTH  committed writes (stats build only).

## Operation
- **Reset values:** state STANDBY; `standby`=1, `active`=0, `contention`=0, counters 0; read pipeline empty; `ram_data` high-Z. Array contents are not cleared.
- **States:** STANDBY, WAKE, ACTIVE.
  - STANDBY and `ram_cs`=0: enter WAKE with wake counter loaded to WAKE_CYCLES-1. If WAKE_CYCLES=0, go directly to ACTIVE and service the access in that same cycle.
  - WAKE: the counter decrements each cycle. At 0 with `ram_cs`=0, enter ACTIVE. Any `ram_cs`=1 cycle returns to STANDBY. Accesses during WAKE are ignored: reads are not queued and writes are dropped.
  - ACTIVE: `ram_cs`=1 for one cycle enters STANDBY. The read pipeline keeps draining; beats already issued are still driven.
- **Write:** ACTIVE, `ram_cs`=0, `ram_we`=0 commits `mem[ram_address] <= ram_data` at the edge.
- **Read:** ACTIVE, `ram_cs`=0, `ram_we`=1 pushes {valid, `mem[ram_address]`} into a READ_LATENCY-deep pipeline.
- **Drive condition:** `ram_data` is driven combinationally from the pipeline head when head valid and `ram_we`=1.
- **Contention:** if the head is valid while `ram_we`=0, the head beat is discarded, not driven, and `contention` is set until reset.
- **Addressing:** the address indexes the array directly; there is no wrap or masking logic, since full width is always in range.
- **Read-after-write:** a read sampled the cycle after a write to the same address returns the new data. A read and write cannot coincide, because `ram_we` selects one.

## Timing
- A read address sampled at edge N appears on `ram_data` during the cycle after edge N+READ_LATENCY-1, so data is valid for capture at edge N+READ_LATENCY.
- With READ_LATENCY=1, back-to-back reads give one word per cycle with no bubble.
- Read→write turnaround: the controller must hold `ram_we`=1 until the last outstanding beat is driven. Otherwise contention is flagged.
- Write→read: no bubble required.
- Wake-up: first serviced access is WAKE_CYCLES+1 cycles after `ram_cs` falls from STANDBY, or the same cycle when WAKE_CYCLES=0.
- `reset` asserted mid-read flushes the pipeline; the bus is high-Z on the following cycle.

## Configuration
- `SRAM_RESPONDER_STATS_EN`:
  - **Defined:** `read_count` increments on each pipeline push and `write_count` on each committed write. Both saturate at all-ones and clear on reset.
  - **Undefined:** both outputs are tied to 0 and no counter logic is built.

## Test plan
- **Reset and wake:** reset, then `ram_cs`=0 with WAKE_CYCLES=2. Required: `standby` 1→0, `active` asserts after 2 cycles, and a write issued during WAKE leaves the addressed word unchanged.
- **Write then read:** in ACTIVE, write 0xA5 to 0x0003, then read 0x0003 with READ_LATENCY=1. Required: `ram_data`=0xA5 one cycle after the address is sampled, and high-Z otherwise.
- **Burst read:** write 0x11,0x22,0x33 to 0x0010..0x0012, then read three consecutive addresses. Required: bus shows 0x11,0x22,0x33 on consecutive cycles.
- **Turnaround violation:** with READ_LATENCY=2, read 0x0010, then drop `ram_we` the next cycle. Required: `contention`=1, the bus is never driven for that beat, and the write still commits.
- **Standby mid-read:** `ram_cs`=1 right after a read is sampled. Required: `standby`=1 and the issued beat is still driven at its scheduled cycle. Reset mid-read: the bus is high-Z next cycle.
- **Stats build:** 5 reads and 3 writes with `SRAM_RESPONDER_STATS_EN` defined. Required: `read_count`=5, `write_count`=3. Same sequence without the macro: both 0.
